// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: credit-limited PC-tagged requests, in-order instruction queue, flush drain.
// Optional misaligned-PC fault state is compiled in when IFETCH_ALIGN_CHECK_EN is defined.
module instruction_fetch_unit #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [63:0] pc_in,
    output logic        pc_advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        flush,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        fetch_fault
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_t;
`else
    typedef enum logic [1:0] {FETCH, DRAIN} state_t;
`endif

    state_t state, state_next;

    logic [63:0] tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tag_wr, tag_rd;
    logic [CNT_W-1:0] outstanding, out_next;

    logic [95:0] q_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] q_wr, q_rd;
    logic [CNT_W-1:0] q_count;

    logic pop, push, resp, fire, aligned, issue_ok, has_credit;
    logic [CNT_W:0] occupancy, credit_limit;

    assign inst_valid = (q_count != '0);
    assign inst_out   = inst_valid ? q_mem[q_rd][31:0]  : 32'd0;
    assign inst_pc    = inst_valid ? q_mem[q_rd][95:32] : 64'd0;
    assign pop        = inst_valid & inst_ready & ~flush;

    // A head leaving this cycle frees its slot in time for a new request, which is what
    // sustains one fetch per cycle with a 1-cycle memory.
    assign occupancy    = {1'b0, outstanding} + {1'b0, q_count};
    assign credit_limit = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
    assign has_credit   = occupancy < credit_limit;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign aligned = (pc_in[1:0] == 2'b00);
`else
    assign aligned = 1'b1;
`endif

    assign issue_ok      = (state == FETCH) & has_credit & ~flush & ~RESET;
    assign fire          = imem_req_valid & imem_req_ready;
    assign pc_advance    = fire;
    assign imem_req_addr = pc_in;
    assign resp          = imem_resp_valid;
    assign push          = resp & (state != DRAIN) & ~flush;
    assign out_next      = outstanding + CNT_W'(fire) - CNT_W'(resp);

    always_ff @(posedge CLOCK) begin
        if (RESET) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = (out_next != '0) ? DRAIN : FETCH;
        end else begin
            case (state)
                DRAIN: if (out_next == '0) state_next = FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
                FETCH: if (issue_ok && !aligned) state_next = FAULT;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = issue_ok & aligned;
        fetch_fault    = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        fetch_fault    = (state == FAULT);
`endif
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            q_count     <= '0;
        end else begin
            outstanding <= out_next;
            if (fire) tag_wr <= tag_wr + PTR_W'(1);
            if (resp) tag_rd <= tag_rd + PTR_W'(1);
            if (flush) begin
                q_wr    <= '0;
                q_rd    <= '0;
                q_count <= '0;
            end else begin
                if (push) q_wr <= q_wr + PTR_W'(1);
                if (pop)  q_rd <= q_rd + PTR_W'(1);
                q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers and counts above.
    always_ff @(posedge CLOCK) begin
        if (fire) tag_mem[tag_wr] <= pc_in;
        if (push) q_mem[q_wr]     <= {tag_mem[tag_rd], imem_resp_data};
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model, in-order memory model, PC register model.
module tb_instruction_fetch_unit;
    localparam int DEPTH = 2;
    localparam int FETCH_M = 0, DRAIN_M = 1, FAULT_M = 2;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] pc_in = '0;
    logic        pc_advance, imem_req_valid, inst_valid, fetch_fault;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr, inst_pc;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        flush = 1'b0;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;

    always #5 CLOCK = ~CLOCK;

    instruction_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .pc_in(pc_in), .pc_advance(pc_advance),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .flush(flush), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    int checks = 0, errors = 0, cyc = 0, lat = 1, mode = FETCH_M, credits = 0;
    logic [63:0] tags[$];
    logic [95:0] insts[$];
    logic [31:0] mem_data[$];
    int          mem_due[$];
    logic [63:0] pc_reg = '0, redirect_pc = '0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_word = 32'h8B020020;
    bit          cur_rst, cur_fl, exp_req, exp_fire, exp_pop, exp_valid, exp_fault, aligned_now;
    logic [95:0] exp_head;

    // Apply one cycle of inputs and derive what the outputs must be from the model.
    task automatic drive(input bit rst, input bit rdy, input bit irdy, input bit fl);
        @(negedge CLOCK);
        RESET = rst; imem_req_ready = rdy; inst_ready = irdy; flush = fl; pc_in = pc_reg;
        if (mem_due.size() > 0 && mem_due[0] == cyc) begin
            imem_resp_valid = 1'b1; imem_resp_data = mem_data[0];
        end else begin
            imem_resp_valid = 1'b0; imem_resp_data = $urandom;
        end
        #1;
        cur_rst = rst; cur_fl = fl;
        exp_valid = insts.size() > 0;
        exp_head = '0;
        if (exp_valid) exp_head = insts[0];
        exp_pop = exp_valid && irdy && !fl && !rst;
        credits = DEPTH - tags.size() - insts.size() + (exp_pop ? 1 : 0);
`ifdef IFETCH_ALIGN_CHECK_EN
        aligned_now = (pc_reg % 4) == 0;
`else
        aligned_now = 1'b1;
`endif
        exp_req = !rst && mode == FETCH_M && credits > 0 && !fl && aligned_now;
        exp_fire = exp_req && rdy;
        exp_fault = (mode == FAULT_M);
    endtask

    // Advance the model, the memory and the PC register across the rising edge.
    task automatic commit();
        logic [63:0] tag;
        logic [31:0] data;
        tag = '0; data = '0;
        @(posedge CLOCK);
        if (cur_rst) begin
            tags.delete(); insts.delete(); mem_data.delete(); mem_due.delete();
            mode = FETCH_M;
        end else begin
            if (imem_resp_valid) begin
                tag = tags.pop_front();
                data = mem_data.pop_front();
                void'(mem_due.pop_front());
            end
            if (exp_pop) void'(insts.pop_front());
            if (imem_resp_valid && mode != DRAIN_M && !cur_fl) insts.push_back({tag, data});
            if (cur_fl) insts.delete();
            if (exp_fire) begin
                tags.push_back(pc_reg);
                mem_data.push_back(fixed_en ? fixed_word : 32'($urandom));
                mem_due.push_back(cyc + lat);
                pc_reg += 64'd4;
            end
            if (cur_fl) begin
                mode = (tags.size() > 0) ? DRAIN_M : FETCH_M;
                pc_reg = redirect_pc;
            end else if (mode == DRAIN_M && tags.size() == 0) begin
                mode = FETCH_M;
            end else if (mode == FETCH_M && credits > 0 && !aligned_now) begin
                mode = FAULT_M;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        commit();
        pc_reg = '0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
            errors++; $display("FAIL reset_cycle_req got=%b/%b exp=0/0", imem_req_valid, pc_advance);
        end
        commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({inst_valid, inst_out, inst_pc, fetch_fault, pc_advance} !== '0) begin
            errors++; $display("FAIL reset_values got v=%b out=%h pc=%h ff=%b adv=%b exp all 0",
                                inst_valid, inst_out, inst_pc, fetch_fault, pc_advance);
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_req got=%b exp=1", imem_req_valid);
        end
        commit();
    endtask

    task automatic test_first_fetch();
        int n;
        n = 0; lat = 1; fixed_en = 1'b1;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            n += int'(pc_advance);
            if (i == 1) begin
                checks++;
                if (pc_advance !== 1'b1 || imem_req_addr !== 64'h0) begin
                    errors++; $display("FAIL first_req adv=%b addr=%h exp 1/0", pc_advance, imem_req_addr);
                end
            end
            if (i == 2) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++; $display("FAIL first_latency valid=%b exp=0", inst_valid);
                end
            end
            if (i == 3) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_out !== 32'h8B020020) begin
                    errors++; $display("FAIL first_inst v=%b pc=%h out=%h exp 1/0/8b020020",
                                        inst_valid, inst_pc, inst_out);
                end
            end
            commit();
        end
        checks++;
        if (n != 12) begin
            errors++; $display("FAIL throughput got=%0d exp=12", n);
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        n = 0; lat = 1;
        do_reset();
        pc_reg = 64'h200;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            n += int'(pc_advance);
            checks++;
            if (imem_req_valid !== exp_req) begin
                errors++; $display("FAIL bp_req cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
            end
            commit();
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL bp_count got=%0d exp=2", n);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
            errors++; $display("FAIL bp_stall got=%b/%b exp=0/0", imem_req_valid, pc_advance);
        end
        commit();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pc_advance !== 1'b1 || imem_req_addr !== 64'h208) begin
            errors++; $display("FAIL bp_resume adv=%b addr=%h exp 1/208", pc_advance, imem_req_addr);
        end
        commit();
    endtask

    task automatic test_flush_drain();
        lat = 3;
        do_reset();
        redirect_pc = 64'h1000;
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, 1'b1, 1'b1, i == 3);
            checks++;
            if (imem_req_valid !== exp_req) begin
                errors++; $display("FAIL drain_req i=%0d got=%b exp=%b", i, imem_req_valid, exp_req);
            end
            if (i >= 3) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++; $display("FAIL drain_valid i=%0d got=%b exp=0", i, inst_valid);
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++; $display("FAIL drain_block i=%0d got=%b exp=0", i, imem_req_valid);
                end
            end
            if (i == 6) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
                    errors++; $display("FAIL drain_exit req=%b addr=%h exp 1/1000", imem_req_valid, imem_req_addr);
                end
            end
            commit();
        end
    endtask

    task automatic test_flush_resp_pop();
        lat = 1;
        do_reset();
        pc_reg = 64'h40; redirect_pc = 64'h2000;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            commit();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL frp_setup valid=%b req=%b exp 1/0", inst_valid, imem_req_valid);
        end
        commit();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
            errors++; $display("FAIL frp_after valid=%b req=%b addr=%h exp 0/1/2000",
                                inst_valid, imem_req_valid, imem_req_addr);
        end
        commit();
    endtask

    task automatic test_reset_midop();
        lat = 1;
        do_reset();
        pc_reg = 64'h80;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            commit();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_before valid=%b req=%b exp 1/0", inst_valid, imem_req_valid);
        end
        commit();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({inst_valid, inst_out, inst_pc, fetch_fault, pc_advance} !== '0) begin
            errors++; $display("FAIL midrst_after v=%b out=%h pc=%h ff=%b adv=%b exp all 0",
                                inst_valid, inst_out, inst_pc, fetch_fault, pc_advance);
        end
        commit();
    endtask

    task automatic test_misalign();
        lat = 1;
        do_reset();
        pc_reg = 64'h6; redirect_pc = 64'h100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
`ifdef IFETCH_ALIGN_CHECK_EN
            checks++;
            if (imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
                errors++; $display("FAIL misalign_req i=%0d got=%b/%b exp=0/0", i, imem_req_valid, pc_advance);
            end
            if (i > 0) begin
                checks++;
                if (fetch_fault !== 1'b1) begin
                    errors++; $display("FAIL misalign_fault i=%0d got=%b exp=1", i, fetch_fault);
                end
            end
`else
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== pc_reg || fetch_fault !== 1'b0) begin
                errors++; $display("FAIL misalign_pass i=%0d req=%b addr=%h ff=%b exp 1/%h/0",
                                    i, imem_req_valid, imem_req_addr, fetch_fault, pc_reg);
            end
`endif
            commit();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        commit();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin
            errors++; $display("FAIL misalign_flush ff=%b req=%b addr=%h exp 0/1/100",
                                fetch_fault, imem_req_valid, imem_req_addr);
        end
        commit();
    endtask

    task automatic test_random();
        bit fl, rdy, irdy;
        for (int seg = 1; seg <= 3; seg++) begin
            lat = seg;
            do_reset();
            pc_reg = 64'($urandom_range(0, 1023)) << 2;
            for (int i = 0; i < 200; i++) begin
                fl = ($urandom_range(0, 15) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                irdy = ($urandom_range(0, 2) != 0);
                redirect_pc = 64'($urandom_range(0, 4095)) << 2;
`ifdef IFETCH_ALIGN_CHECK_EN
                if ($urandom_range(0, 7) == 0) redirect_pc += 64'd2;
`endif
                drive(1'b0, rdy, irdy, fl);
                checks++;
                if (imem_req_valid !== exp_req) begin
                    errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_req);
                end
                checks++;
                if (pc_advance !== exp_fire) begin
                    errors++; $display("FAIL rnd_adv cyc=%0d got=%b exp=%b", cyc, pc_advance, exp_fire);
                end
                checks++;
                if (imem_req_addr !== pc_reg) begin
                    errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, pc_reg);
                end
                checks++;
                if (inst_valid !== exp_valid) begin
                    errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_valid);
                end
                if (exp_valid) begin
                    checks++;
                    if ({inst_pc, inst_out} !== exp_head) begin
                        errors++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, {inst_pc, inst_out}, exp_head);
                    end
                end
                checks++;
                if (fetch_fault !== exp_fault) begin
                    errors++; $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", cyc, fetch_fault, exp_fault);
                end
                commit();
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_flush_drain();
        test_flush_resp_pop();
        test_reset_midop();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
